// File: rtl/sequenciador_if.sv
// Button/control inputs and registered state-code outputs of the sequencer.
// The state code is consumed by the downstream interpretador decoder.
interface sequenciador_if;
    logic       botao;
    logic       pausa;
    logic       ciclico;
    logic [4:0] estado;
    logic       ocupado;
    logic       fim;

    modport master (output botao, pausa, ciclico, input estado, ocupado, fim);
    modport slave  (input botao, pausa, ciclico, output estado, ocupado, fim);
endinterface

// File: rtl/sequenciador.sv
// Steps a 5-bit state code through 0..ULTIMO at a prescaled rate on each button press.
// All outputs are registered so the downstream decoder never sees glitches.
module sequenciador #(
    parameter int unsigned DIVISOR = 25_000_000,
    parameter int unsigned ULTIMO  = 8,
    parameter logic [4:0]  APAGADO = 5'b01001
) (
    input logic          clk,
    input logic          rst_n,
    sequenciador_if.slave bus
);
    localparam int PW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] RODANDO = 2'd1;
    localparam logic [1:0] PAUSADO = 2'd2;
    localparam logic [1:0] FIM     = 2'd3;

    logic [1:0]    st_q, st_d;
    logic [4:0]    idx_q, idx_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    estado_q, estado_d;
    logic          ocupado_q, ocupado_d;
    logic          fim_q, fim_d;
    logic          s1_q, s2_q, s3_q;
    logic          press;

    // s3 remembers the previous synchronized level so a held button fires once
    assign press = s2_q & ~s3_q;

    always_comb begin
        st_d    = st_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        fim_d   = 1'b0;
        case (st_q)
            OCIOSO, FIM: begin
                presc_d = '0;
                if (press) begin
                    st_d  = RODANDO;
                    idx_d = '0;
                end
            end
            RODANDO, PAUSADO: begin
                if (press) begin
                    st_d    = RODANDO;
                    idx_d   = '0;
                    presc_d = '0;
                end else if (bus.pausa) begin
                    st_d = PAUSADO;
                end else begin
                    // Leaving pause counts on the same edge, so a pause costs exactly its length
                    st_d = RODANDO;
                    if (presc_q == PW'(DIVISOR - 1)) begin
                        presc_d = '0;
                        if (idx_q < 5'(ULTIMO)) begin
                            idx_d = idx_q + 5'd1;
                        end else if (bus.ciclico) begin
                            idx_d = '0;
                        end else begin
                            st_d  = FIM;
                            fim_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            default: st_d = OCIOSO;
        endcase
        ocupado_d = (st_d == RODANDO) || (st_d == PAUSADO);
        estado_d  = ocupado_d ? idx_d : APAGADO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= OCIOSO;
            idx_q     <= '0;
            presc_q   <= '0;
            estado_q  <= APAGADO;
            ocupado_q <= 1'b0;
            fim_q     <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
        end else begin
            st_q      <= st_d;
            idx_q     <= idx_d;
            presc_q   <= presc_d;
            estado_q  <= estado_d;
            ocupado_q <= ocupado_d;
            fim_q     <= fim_d;
            s1_q      <= bus.botao;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
        end
    end

    assign bus.estado  = estado_q;
    assign bus.ocupado = ocupado_q;
    assign bus.fim     = fim_q;
endmodule
